br_param: RTL



---
 rtl/br_pkg.sv | 13 +
 rtl/br_clr_fsm.sv | 61 ++++++
 rtl/br_param.sv | 77 +++++++
 3 files changed

// File: rtl/br_pkg.sv
// Shared constants and clear-FSM state encoding for the parametrised register bank.
package br_pkg;

    localparam int BR_XLEN = 32;
    localparam int BR_NREG = 32;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/br_clr_fsm.sv
// Bulk-clear sequencer: sweeps one register per cycle and pulses done afterwards.
module br_clr_fsm
    import br_pkg::*;
#(
    parameter  int NREG = BR_NREG,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_stb,
    output logic [AW-1:0] clr_addr,
    output clr_state_e    state_o
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
            CLR_CLEAR: begin
                // Last index is cleared on the same edge that moves to DONE.
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = CLR_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    assign clr_busy = (state_q == CLR_CLEAR);
    assign clr_done = (state_q == CLR_DONE);
    assign clr_stb  = (state_q == CLR_CLEAR);
    assign clr_addr = cnt_q;
    assign state_o  = state_q;

endmodule

// File: rtl/br_param.sv
// Parametrised register bank: NRD combinational read ports, one write port,
// optional hard-wired zero register and write bypass, plus a sequential bulk clear.
module br_param
    import br_pkg::*;
#(
    parameter  int XLEN    = BR_XLEN,
    parameter  int NREG    = BR_NREG,
    parameter  int NRD     = 2,
    parameter  int BYPASS  = 1,
    parameter  int ZERO_R0 = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                we,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    logic [XLEN-1:0] mem_q [NREG];
    logic            clr_stb;
    logic [AW-1:0]   clr_addr;
    clr_state_e      clr_state;
    logic            wr_qual;

    br_clr_fsm #(.NREG(NREG)) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_stb  (clr_stb),
        .clr_addr (clr_addr),
        .state_o  (clr_state)
    );

    // Writes are only honoured while the clear engine is idle; dropped otherwise.
    assign wr_qual = we && (clr_state == CLR_IDLE) && !((ZERO_R0 != 0) && (wa == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_stb) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_qual) begin
            mem_q[wa] <= wd;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = ra[k*AW +: AW];

        // Zero-register override has priority over bypass, bypass over storage.
        always_comb begin
            data = mem_q[addr];
            if ((BYPASS != 0) && wr_qual && (wa == addr)) begin
                data = wd;
            end
            if ((ZERO_R0 != 0) && (addr == '0)) begin
                data = '0;
            end
        end

        assign rd[k*XLEN +: XLEN] = data;
    end

endmodule
